sram_1p_bm_march_bist: RTL and testbench
========================================

Name: sram_1p_bm_march_bist

Overview:
Parametrised single-port SRAM model with per-bit write mask and an embedded March C- BIST engine that takes over the array port when started. It generalises the fixed 1024x8 masked/BIST macro to any width and depth, and replaces the external BIST port with a self-sequencing test and fail reporting. It sits wherever an SRAM macro is instantiated in DFT example SoCs, so memory test runs without an external controller.

Parameters:
DATA_W, 8, word width in bits (1..64)
ADDR_W, 10, address width
NUM_WORDS, 1024, implemented words; must satisfy 2 <= NUM_WORDS <= 2**ADDR_W

Ports:
A_CLK  input  1  clock; all state updates on posedge
A_RST_N  input  1  asynchronous active-low reset
A_MEN  input  1  functional memory enable
A_WEN  input  1  functional write enable (qualified by A_MEN)
A_REN  input  1  functional read enable (qualified by A_MEN)
A_ADDR  input  ADDR_W  functional address
A_DIN  input  DATA_W  functional write data
A_BM  input  DATA_W  functional bit mask; 1 = bit written
A_DOUT  output  DATA_W  read data
A_BIST_START  input  1  start March C-; sampled only when idle
A_BIST_BUSY  output  1  BIST owns the array
A_BIST_DONE  output  1  one-cycle completion pulse
A_BIST_FAIL  output  1  sticky mismatch flag
A_BIST_FAIL_ADDR  output  ADDR_W  address of first mismatch
A_BIST_FAIL_ELEM  output  3  March element index (0..5) of first mismatch
A_INJ_EN  input  1  fault-injection enable (DFT validation)
A_INJ_ADDR  input  ADDR_W  injected-fault address
A_INJ_MASK  input  DATA_W  bits forced to 1 on reads of A_INJ_ADDR

Behaviour:
- Reset: A_DOUT=0, BUSY=0, DONE=0, FAIL=0, FAIL_ADDR=0, FAIL_ELEM=0. Array contents are not reset; the bench must not rely on them.
- Write (MEN&WEN, posedge): mem[a] = (mem[a] & ~BM) | (DIN & BM).
- Read (MEN&REN): A_DOUT is updated at the same edge (1-cycle latency) and held until the next read. Write-only or idle cycles leave A_DOUT unchanged.
- WEN&REN together: write is applied first, and A_DOUT returns the post-write word.
- Address >= NUM_WORDS: write ignored, read returns 0.
- Injection: when A_INJ_EN is high and the read address equals A_INJ_ADDR, returned data = stored | A_INJ_MASK. Stored contents are untouched. This applies to functional and BIST reads.
- FSM states: IDLE, RUN, FLUSH, DONE.
  - IDLE->RUN when START=1. At the same edge FAIL, FAIL_ADDR and FAIL_ELEM clear. START in any other state is ignored.
  - RUN issues one op per cycle with BM all ones, in this order:
    - M0 up(w0)
    - M1 up(r0,w1)
    - M2 up(r1,w0)
    - M3 down(r0,w1)
    - M4 down(r1,w0)
    - M5 up(r0)
  - Up = 0..NUM_WORDS-1; down = NUM_WORDS-1..0. w0/w1 = all-zeros/all-ones word.
  - Total RUN cycles = 10*NUM_WORDS.
  - RUN->FLUSH after the last op. FLUSH is one cycle, used for the final compare. FLUSH->DONE, then DONE->IDLE after one cycle.
- BUSY is high in RUN and FLUSH, i.e. 10*NUM_WORDS+1 cycles starting the cycle after START. DONE is high only in the DONE state.
- Compare: each read's data is checked the following cycle against the expected word. On the first mismatch, FAIL is set and FAIL_ADDR/FAIL_ELEM are captured. Later mismatches do not overwrite them. FAIL holds until the next START or reset.
- While BUSY: functional MEN/WEN/REN are ignored (no array effect), and A_DOUT reflects BIST reads.
- Reset mid-BIST: return to IDLE with all outputs at reset values; no DONE pulse.

Decomposition:
- Package sram_bist_pkg holds:
  - march_elem_e (M0..M5)
  - op_e (W0, W1, R0, R1)
  - direction/ops-per-element constant tables
  - fsm_state_e
- Sub-module sram_1p_bm_array holds the masked-write array, out-of-range handling, injection and the A_DOUT register.
- The top level muxes the array port and hosts the March FSM, address counter and compare stage.

Test Plan:
1. Write 0xA5 @3 BM=0xFF, then write 0x0F @3 BM=0xF0, then read @3 -> A_DOUT=0x05 one edge after the read. A_DOUT holds 0x05 through two idle cycles.
2. MEN&WEN&REN @5, DIN=0x3C, BM=0xFF -> A_DOUT=0x3C at the same edge. Read @1024 with NUM_WORDS=1000 -> A_DOUT=0x00.
3. Defaults, START pulse -> BUSY high for exactly 10241 cycles, DONE single pulse, FAIL=0.
4. INJ_EN=1, INJ_ADDR=17, INJ_MASK=0x01, then START -> FAIL=1, FAIL_ADDR=17, FAIL_ELEM=1. DONE still pulses after full length.
5. Assert A_RST_N low at RUN cycle 500 -> all outputs 0 immediately. A new START then runs a full clean pass.
6. Functional write 0xFF @0 issued during BUSY -> after DONE, a read @0 returns 0x00 (M5 left all-zeros). A second START during BUSY is ignored, and BUSY length is unchanged.

Source files
------------

// File: rtl/sram_bist_pkg.sv
// Shared types and March C- tables for the single-port masked SRAM with BIST.
// Elements M1..M4 issue two ops per address; M3/M4 walk the array downwards.
package sram_bist_pkg;

   typedef enum logic [2:0] {
      M0, M1, M2, M3, M4, M5
   } march_elem_e;

   typedef enum logic [1:0] {
      W0 = 2'b00,
      W1 = 2'b01,
      R0 = 2'b10,
      R1 = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_FLUSH,
      S_DONE
   } fsm_state_e;

   localparam logic [7:0] ELEM_DOWN    = 8'b0001_1000;
   localparam logic [7:0] ELEM_TWO_OPS = 8'b0001_1110;

   function automatic op_e elem_op(
      input march_elem_e e,
      input logic        idx
   );
      op_e o;
      o = W0;
      case (e)
         M0:      o = W0;
         M1:      o = idx ? W1 : R0;
         M2:      o = idx ? W0 : R1;
         M3:      o = idx ? W1 : R0;
         M4:      o = idx ? W0 : R1;
         M5:      o = R0;
         default: o = W0;
      endcase
      return o;
   endfunction

endpackage

// File: rtl/sram_1p_bm_array.sv
// Masked-write storage array with out-of-range guard, read-fault injection
// and the registered read port (write-first on simultaneous write/read).
module sram_1p_bm_array #(
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 10,
   parameter int NUM_WORDS = 1024
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_men,
   input  logic              i_wen,
   input  logic              i_ren,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_din,
   input  logic [DATA_W-1:0] i_bm,
   input  logic              i_inj_en,
   input  logic [ADDR_W-1:0] i_inj_addr,
   input  logic [DATA_W-1:0] i_inj_mask,
   output logic [DATA_W-1:0] o_dout
);

   localparam int IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam logic [ADDR_W:0] NW = (ADDR_W+1)'(NUM_WORDS);

   logic [DATA_W-1:0] r_mem [NUM_WORDS];
   logic [DATA_W-1:0] r_dout;

   logic              w_in;
   logic [IW-1:0]     w_idx;
   logic [DATA_W-1:0] w_old;
   logic [DATA_W-1:0] w_new;
   logic [DATA_W-1:0] w_word;
   logic [DATA_W-1:0] w_rdata;

   assign w_in  = ({1'b0, i_addr} < NW);
   assign w_idx = i_addr[IW-1:0];

   always_comb begin
      w_old   = w_in ? r_mem[w_idx] : '0;
      w_new   = (w_old & ~i_bm) | (i_din & i_bm);
      w_word  = (i_wen && w_in) ? w_new : w_old;
      w_rdata = w_word;
      // injected bits only corrupt the returned data, never the cell
      if (i_inj_en && w_in && (i_addr == i_inj_addr)) begin
         w_rdata = w_word | i_inj_mask;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_men && i_wen && w_in) begin
         r_mem[w_idx] <= w_new;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_dout <= '0;
      end else if (i_men && i_ren) begin
         r_dout <= w_rdata;
      end
   end

   assign o_dout = r_dout;

endmodule

// File: rtl/sram_1p_bm_march_bist.sv
// Single-port masked SRAM with an embedded March C- engine that owns the
// array port while busy and records the first failing address/element.
module sram_1p_bm_march_bist
   import sram_bist_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 10,
   parameter int NUM_WORDS = 1024
) (
   input  logic              A_CLK,
   input  logic              A_RST_N,
   input  logic              A_MEN,
   input  logic              A_WEN,
   input  logic              A_REN,
   input  logic [ADDR_W-1:0] A_ADDR,
   input  logic [DATA_W-1:0] A_DIN,
   input  logic [DATA_W-1:0] A_BM,
   output logic [DATA_W-1:0] A_DOUT,
   input  logic              A_BIST_START,
   output logic              A_BIST_BUSY,
   output logic              A_BIST_DONE,
   output logic              A_BIST_FAIL,
   output logic [ADDR_W-1:0] A_BIST_FAIL_ADDR,
   output logic [2:0]        A_BIST_FAIL_ELEM,
   input  logic              A_INJ_EN,
   input  logic [ADDR_W-1:0] A_INJ_ADDR,
   input  logic [DATA_W-1:0] A_INJ_MASK
);

   localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(NUM_WORDS - 1);
   localparam logic [ADDR_W-1:0] ONE_A  = ADDR_W'(1);

   fsm_state_e        r_state;
   fsm_state_e        w_next;
   march_elem_e       r_elem;
   logic              r_op;
   logic [ADDR_W-1:0] r_addr;

   logic              r_cmp_vld;
   logic              r_cmp_one;
   logic [ADDR_W-1:0] r_cmp_addr;
   march_elem_e       r_cmp_elem;

   logic              r_fail;
   logic [ADDR_W-1:0] r_fail_addr;
   logic [2:0]        r_fail_elem;

   op_e               w_op;
   march_elem_e       w_nelem;
   logic              w_run;
   logic              w_busy;
   logic              w_done;
   logic              w_rd;
   logic              w_one;
   logic              w_last_op;
   logic              w_last_addr;
   logic              w_last;
   logic              w_start;
   logic              w_mis;
   logic [ADDR_W-1:0] w_first;

   logic              w_men;
   logic              w_wen;
   logic              w_ren;
   logic [ADDR_W-1:0] w_addr;
   logic [DATA_W-1:0] w_din;
   logic [DATA_W-1:0] w_bm;
   logic [DATA_W-1:0] w_dout;

   assign w_op    = elem_op(r_elem, r_op);
   assign w_rd    = (w_op == R0) || (w_op == R1);
   assign w_one   = (w_op == W1) || (w_op == R1);
   assign w_nelem = march_elem_e'(r_elem + 3'd1);
   assign w_first = ELEM_DOWN[w_nelem] ? LAST_A : '0;

   assign w_last_op   = !ELEM_TWO_OPS[r_elem] || r_op;
   assign w_last_addr = ELEM_DOWN[r_elem] ? (r_addr == '0)
                                          : (r_addr == LAST_A);
   assign w_last      = (r_elem == M5) && w_last_op && w_last_addr;
   assign w_start     = (r_state == S_IDLE) && A_BIST_START;

   always_ff @(posedge A_CLK or negedge A_RST_N) begin
      if (!A_RST_N) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      w_run  = 1'b0;
      w_busy = 1'b0;
      w_done = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (A_BIST_START) w_next = S_RUN;
         end
         S_RUN: begin
            w_run  = 1'b1;
            w_busy = 1'b1;
            if (w_last) w_next = S_FLUSH;
         end
         S_FLUSH: begin
            w_busy = 1'b1;
            w_next = S_DONE;
         end
         S_DONE: begin
            w_done = 1'b1;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge A_CLK or negedge A_RST_N) begin
      if (!A_RST_N) begin
         r_elem <= M0;
         r_op   <= 1'b0;
         r_addr <= '0;
      end else if (w_start) begin
         r_elem <= M0;
         r_op   <= 1'b0;
         r_addr <= '0;
      end else if (w_run) begin
         if (!w_last_op) begin
            r_op <= 1'b1;
         end else begin
            r_op <= 1'b0;
            if (!w_last_addr) begin
               r_addr <= ELEM_DOWN[r_elem] ? r_addr - ONE_A
                                           : r_addr + ONE_A;
            end else if (r_elem != M5) begin
               r_elem <= w_nelem;
               r_addr <= w_first;
            end
         end
      end
   end

   // read data lands in A_DOUT one edge later; compare it the cycle after
   assign w_mis = r_cmp_vld && (w_dout != {DATA_W{r_cmp_one}});

   always_ff @(posedge A_CLK or negedge A_RST_N) begin
      if (!A_RST_N) begin
         r_cmp_vld   <= 1'b0;
         r_cmp_one   <= 1'b0;
         r_cmp_addr  <= '0;
         r_cmp_elem  <= M0;
         r_fail      <= 1'b0;
         r_fail_addr <= '0;
         r_fail_elem <= '0;
      end else begin
         r_cmp_vld  <= w_run && w_rd;
         r_cmp_one  <= w_one;
         r_cmp_addr <= r_addr;
         r_cmp_elem <= r_elem;
         if (w_start) begin
            r_fail      <= 1'b0;
            r_fail_addr <= '0;
            r_fail_elem <= '0;
         end else if (w_mis && !r_fail) begin
            r_fail      <= 1'b1;
            r_fail_addr <= r_cmp_addr;
            r_fail_elem <= r_cmp_elem;
         end
      end
   end

   assign w_men  = w_busy ? w_run : A_MEN;
   assign w_wen  = w_busy ? (w_run && !w_rd) : A_WEN;
   assign w_ren  = w_busy ? (w_run && w_rd) : A_REN;
   assign w_addr = w_busy ? r_addr : A_ADDR;
   assign w_din  = w_busy ? {DATA_W{w_one}} : A_DIN;
   assign w_bm   = w_busy ? {DATA_W{1'b1}} : A_BM;

   sram_1p_bm_array #(
      .DATA_W    (DATA_W),
      .ADDR_W    (ADDR_W),
      .NUM_WORDS (NUM_WORDS)
   ) u_array (
      .i_clk      (A_CLK),
      .i_rst_n    (A_RST_N),
      .i_men      (w_men),
      .i_wen      (w_wen),
      .i_ren      (w_ren),
      .i_addr     (w_addr),
      .i_din      (w_din),
      .i_bm       (w_bm),
      .i_inj_en   (A_INJ_EN),
      .i_inj_addr (A_INJ_ADDR),
      .i_inj_mask (A_INJ_MASK),
      .o_dout     (w_dout)
   );

   assign A_DOUT           = w_dout;
   assign A_BIST_BUSY      = w_busy;
   assign A_BIST_DONE      = w_done;
   assign A_BIST_FAIL      = r_fail;
   assign A_BIST_FAIL_ADDR = r_fail_addr;
   assign A_BIST_FAIL_ELEM = r_fail_elem;

endmodule

// File: tb/tb_sram_1p_bm_march_bist.sv
// Directed bench: masked writes, range guard, March C- length, injection,
// mid-run reset and functional lockout while the BIST is busy.
module tb_sram_1p_bm_march_bist;

   logic       clk;
   logic       rst_n;
   logic       men, wen, ren;
   logic [9:0] addr;
   logic [7:0] din, bm, dout;
   logic       start, busy, done, fail;
   logic [9:0] fail_addr;
   logic [2:0] fail_elem;
   logic       inj_en;
   logic [9:0] inj_addr;
   logic [7:0] inj_mask;

   logic        men2, wen2, ren2;
   logic [10:0] addr2;
   logic [7:0]  din2, bm2, dout2;
   logic        busy2, done2, fail2;
   logic [10:0] fail_addr2;
   logic [2:0]  fail_elem2;

   int n_cmp;
   int n_err;

   sram_1p_bm_march_bist u_dut (
      .A_CLK            (clk),
      .A_RST_N          (rst_n),
      .A_MEN            (men),
      .A_WEN            (wen),
      .A_REN            (ren),
      .A_ADDR           (addr),
      .A_DIN            (din),
      .A_BM             (bm),
      .A_DOUT           (dout),
      .A_BIST_START     (start),
      .A_BIST_BUSY      (busy),
      .A_BIST_DONE      (done),
      .A_BIST_FAIL      (fail),
      .A_BIST_FAIL_ADDR (fail_addr),
      .A_BIST_FAIL_ELEM (fail_elem),
      .A_INJ_EN         (inj_en),
      .A_INJ_ADDR       (inj_addr),
      .A_INJ_MASK       (inj_mask)
   );

   sram_1p_bm_march_bist #(
      .DATA_W    (8),
      .ADDR_W    (11),
      .NUM_WORDS (1000)
   ) u_dut2 (
      .A_CLK            (clk),
      .A_RST_N          (rst_n),
      .A_MEN            (men2),
      .A_WEN            (wen2),
      .A_REN            (ren2),
      .A_ADDR           (addr2),
      .A_DIN            (din2),
      .A_BM             (bm2),
      .A_DOUT           (dout2),
      .A_BIST_START     (1'b0),
      .A_BIST_BUSY      (busy2),
      .A_BIST_DONE      (done2),
      .A_BIST_FAIL      (fail2),
      .A_BIST_FAIL_ADDR (fail_addr2),
      .A_BIST_FAIL_ELEM (fail_elem2),
      .A_INJ_EN         (1'b0),
      .A_INJ_ADDR       (11'd0),
      .A_INJ_MASK       (8'd0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input logic w, input logic r, input logic [9:0] a,
                      input logic [7:0] d, input logic [7:0] m);
      men = w | r; wen = w; ren = r;
      addr = a; din = d; bm = m;
      @(posedge clk); #1;
      men = 1'b0; wen = 1'b0; ren = 1'b0;
      @(negedge clk);
   endtask

   task automatic cyc2(input logic w, input logic r, input logic [10:0] a,
                       input logic [7:0] d);
      men2 = w | r; wen2 = w; ren2 = r;
      addr2 = a; din2 = d; bm2 = 8'hFF;
      @(posedge clk); #1;
      men2 = 1'b0; wen2 = 1'b0; ren2 = 1'b0;
      @(negedge clk);
   endtask

   task automatic run_bist(input string tag, input bit extra);
      int n;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n = 0;
      while (busy && n < 20000) begin
         n++;
         start = extra && (n == 100);
         men   = extra && (n == 200);
         wen   = men;
         ren   = 1'b0;
         addr  = 10'd0;
         din   = 8'hFF;
         bm    = 8'hFF;
         @(posedge clk); #1;
      end
      start = 1'b0; men = 1'b0; wen = 1'b0;
      chk({tag, "_busy_len"}, 64'(n), 64'd10241);
      chk({tag, "_done_hi"}, 64'(done), 64'd1);
      @(posedge clk); #1;
      chk({tag, "_done_lo"}, 64'(done), 64'd0);
      chk({tag, "_idle"}, 64'(busy), 64'd0);
      @(negedge clk);
   endtask

   initial begin
      n_cmp = 0; n_err = 0;
      rst_n = 1'b0;
      men = 0; wen = 0; ren = 0; addr = 0; din = 0; bm = 0;
      start = 0; inj_en = 0; inj_addr = 0; inj_mask = 0;
      men2 = 0; wen2 = 0; ren2 = 0; addr2 = 0; din2 = 0; bm2 = 0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      chk("rst_dout", 64'(dout), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_fail", 64'(fail), 64'd0);
      chk("rst_faddr", 64'(fail_addr), 64'd0);
      chk("rst_felem", 64'(fail_elem), 64'd0);

      cyc(1, 0, 10'd3, 8'hA5, 8'hFF);
      cyc(1, 0, 10'd3, 8'h0F, 8'hF0);
      cyc(0, 1, 10'd3, 8'h00, 8'h00);
      chk("mask_rd", 64'(dout), 64'h05);
      cyc(0, 0, 10'd3, 8'h00, 8'h00);
      chk("hold1", 64'(dout), 64'h05);
      cyc(0, 0, 10'd3, 8'h00, 8'h00);
      chk("hold2", 64'(dout), 64'h05);
      cyc(1, 0, 10'd9, 8'h77, 8'hFF);
      chk("wr_only_hold", 64'(dout), 64'h05);

      cyc(1, 1, 10'd5, 8'h3C, 8'hFF);
      chk("wr_rd_same", 64'(dout), 64'h3C);
      cyc(1, 1, 10'd5, 8'hC3, 8'h0F);
      chk("wr_rd_mask", 64'(dout), 64'h33);

      cyc2(1, 1, 11'd0, 8'h77);
      chk("d2_wr_rd", 64'(dout2), 64'h77);
      cyc2(0, 1, 11'd1024, 8'h00);
      chk("d2_oor_rd", 64'(dout2), 64'h00);
      cyc2(0, 1, 11'd0, 8'h00);
      chk("d2_rd0", 64'(dout2), 64'h77);
      cyc2(1, 0, 11'd1000, 8'h55);
      cyc2(0, 1, 11'd1000, 8'h00);
      chk("d2_oor_wr", 64'(dout2), 64'h00);

      run_bist("clean", 1'b0);
      chk("clean_fail", 64'(fail), 64'd0);

      inj_en = 1'b1; inj_addr = 10'd17; inj_mask = 8'h01;
      run_bist("inj", 1'b0);
      chk("inj_fail", 64'(fail), 64'd1);
      chk("inj_faddr", 64'(fail_addr), 64'd17);
      chk("inj_felem", 64'(fail_elem), 64'd1);
      cyc(0, 1, 10'd17, 8'h00, 8'h00);
      chk("inj_func_rd", 64'(dout), 64'h01);
      chk("inj_fail_hold", 64'(fail), 64'd1);
      inj_en = 1'b0;

      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (500) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("mrst_busy", 64'(busy), 64'd0);
      chk("mrst_done", 64'(done), 64'd0);
      chk("mrst_dout", 64'(dout), 64'd0);
      chk("mrst_fail", 64'(fail), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_bist("after_rst", 1'b0);
      chk("after_rst_fail", 64'(fail), 64'd0);

      run_bist("lockout", 1'b1);
      chk("lockout_fail", 64'(fail), 64'd0);
      cyc(0, 1, 10'd0, 8'h00, 8'h00);
      chk("lockout_rd0", 64'(dout), 64'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
